// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK with memory
// handshake, illegal-opcode and memory-timeout traps, and a retired-instruction counter.
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT  = 255,
  parameter int RETIRE_CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              dec_opcode,
  input  logic [4:0]              dec_rd,
  input  logic                    dec_reg_write,
  input  logic                    dec_mem_read,
  input  logic                    dec_mem_write,
  input  logic                    dec_branch,
  input  logic                    dec_jump,
  input  logic                    branch_taken,
  input  logic                    mem_ready,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic                    mem_addr_sel,
  output logic                    ir_load,
  output logic                    alu_a_sel,
  output logic                    pc_write,
  output logic [1:0]              pc_sel,
  output logic                    rf_we,
  output logic [1:0]              wb_sel,
  output logic                    trap,
  output logic [1:0]              trap_cause,
  output logic                    retire,
  output logic [RETIRE_CNT_W-1:0] retire_count,
  output logic [2:0]              state_dbg
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam int TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t                  state, state_next;
  logic [TO_W-1:0]         to_cnt, to_cnt_next;
  logic [1:0]              cause, cause_next;
  logic [RETIRE_CNT_W-1:0] rcnt;

  logic       req, we, addr_sel, irl, a_sel, pcw, rfw, ret;
  logic [1:0] pcs, wbs;
  logic       legal_op, is_auipc, timeout_hit;

  always_comb begin
    case (dec_opcode)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal_op = 1'b1;
      default:                           legal_op = 1'b0;
    endcase
  end

  assign is_auipc = (dec_opcode == OP_AUIPC);
  // A wait of MEM_TIMEOUT cycles traps in its last cycle unless ready arrives then.
  assign timeout_hit = (MEM_TIMEOUT != 0) && (to_cnt == TO_W'(MEM_TIMEOUT - 1));

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    cause_next = cause;
    req        = 1'b0;
    we         = 1'b0;
    addr_sel   = 1'b0;
    irl        = 1'b0;
    a_sel      = 1'b0;
    pcw        = 1'b0;
    pcs        = 2'b00;
    rfw        = 1'b0;
    wbs        = 2'b00;
    ret        = 1'b0;
    case (state)
      S_FETCH: begin
        req = 1'b1;
        if (mem_ready) begin
          irl        = 1'b1;
          state_next = S_DECODE;
        end else if (timeout_hit) begin
          state_next = S_TRAP;
          cause_next = 2'b10;
        end
      end
      S_DECODE: begin
        if (legal_op) begin
          state_next = S_EXECUTE;
        end else begin
          state_next = S_TRAP;
          cause_next = 2'b01;
        end
      end
      S_EXECUTE: begin
        a_sel = is_auipc;
        if (dec_mem_read || dec_mem_write) begin
          state_next = S_MEM;
        end else if (dec_branch) begin
          pcw        = 1'b1;
          pcs        = branch_taken ? 2'b01 : 2'b00;
          ret        = 1'b1;
          state_next = S_FETCH;
        end else begin
          state_next = S_WRITEBACK;
        end
      end
      S_MEM: begin
        req      = 1'b1;
        addr_sel = 1'b1;
        we       = dec_mem_write;
        if (mem_ready) begin
          if (dec_mem_write) begin
            pcw        = 1'b1;
            ret        = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_WRITEBACK;
          end
        end else if (timeout_hit) begin
          state_next = S_TRAP;
          cause_next = 2'b10;
        end
      end
      S_WRITEBACK: begin
        rfw   = dec_reg_write && (dec_rd != 5'd0);
        a_sel = is_auipc;
        if (dec_mem_read)               wbs = 2'b01;
        else if (dec_jump)              wbs = 2'b10;
        else if (dec_opcode == OP_LUI)  wbs = 2'b11;
        pcw = 1'b1;
        if (dec_opcode == OP_JAL)       pcs = 2'b01;
        else if (dec_opcode == OP_JALR) pcs = 2'b10;
        ret        = 1'b1;
        state_next = S_FETCH;
      end
      S_TRAP: ;
      default: state_next = S_FETCH;
    endcase
    to_cnt_next = (req && !mem_ready && (state_next == state)) ? to_cnt + 1'b1 : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_FETCH;
      to_cnt <= '0;
      cause  <= 2'b00;
      rcnt   <= '0;
    end else begin
      state  <= state_next;
      to_cnt <= to_cnt_next;
      cause  <= cause_next;
      rcnt   <= rcnt + RETIRE_CNT_W'(ret);
    end
  end

  // Reset forces every output low immediately, including a pending memory request.
  assign mem_req      = req      & ~rst;
  assign mem_we       = we       & ~rst;
  assign mem_addr_sel = addr_sel & ~rst;
  assign ir_load      = irl      & ~rst;
  assign alu_a_sel    = a_sel    & ~rst;
  assign pc_write     = pcw      & ~rst;
  assign pc_sel       = rst ? 2'b00 : pcs;
  assign rf_we        = rfw      & ~rst;
  assign wb_sel       = rst ? 2'b00 : wbs;
  assign retire       = ret      & ~rst;
  assign trap         = (state == S_TRAP) & ~rst;
  assign trap_cause   = rst ? 2'b00 : cause;
  assign retire_count = rst ? '0 : rcnt;
  assign state_dbg    = rst ? 3'd0 : state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: directed vector table, random
// instruction stream against a phase-timeline model, trap, timeout and reset cases.
module tb_multicycle_control_fsm;

  localparam int CW  = 4;
  localparam int TMO = 255;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    dec_opcode;
  logic [4:0]    dec_rd;
  logic          dec_reg_write, dec_mem_read, dec_mem_write, dec_branch, dec_jump;
  logic          branch_taken, mem_ready;
  logic          mem_req, mem_we, mem_addr_sel, ir_load, alu_a_sel, pc_write, rf_we;
  logic [1:0]    pc_sel, wb_sel, trap_cause;
  logic          trap, retire;
  logic [CW-1:0] retire_count;
  logic [2:0]    state_dbg;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.MEM_TIMEOUT(TMO), .RETIRE_CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .dec_opcode(dec_opcode), .dec_rd(dec_rd), .dec_reg_write(dec_reg_write),
    .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write),
    .dec_branch(dec_branch), .dec_jump(dec_jump),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_load(ir_load),
    .alu_a_sel(alu_a_sel), .pc_write(pc_write), .pc_sel(pc_sel), .rf_we(rf_we),
    .wb_sel(wb_sel), .trap(trap), .trap_cause(trap_cause), .retire(retire),
    .retire_count(retire_count), .state_dbg(state_dbg)
  );

  typedef struct packed {
    logic          mem_req, mem_we, mem_addr_sel, ir_load, alu_a_sel, pc_write;
    logic [1:0]    pc_sel;
    logic          rf_we;
    logic [1:0]    wb_sel;
    logic          trap;
    logic [1:0]    trap_cause;
    logic          retire;
    logic [2:0]    state_dbg;
    logic [CW-1:0] retire_count;
  } out_t;

  typedef struct packed { logic rw, mr, mw, br, jp; } dec_t;
  typedef enum { PH_F, PH_D, PH_E, PH_M, PH_W } phase_e;

  typedef struct {
    logic [6:0] op;
    logic [4:0] rd;
    int         fw, mw;
    logic       taken;
    int         cyc;
    logic       rf;
    logic [1:0] wb, pc;
  } vec_t;

  int            checks = 0;
  int            failures = 0;
  logic [CW-1:0] model_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic out_t sample();
    out_t o;
    o.mem_req = mem_req; o.mem_we = mem_we; o.mem_addr_sel = mem_addr_sel;
    o.ir_load = ir_load; o.alu_a_sel = alu_a_sel; o.pc_write = pc_write;
    o.pc_sel = pc_sel; o.rf_we = rf_we; o.wb_sel = wb_sel; o.trap = trap;
    o.trap_cause = trap_cause; o.retire = retire; o.state_dbg = state_dbg;
    o.retire_count = retire_count;
    return o;
  endfunction

  function automatic dec_t decode(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LUI, OP_AUIPC: return '{rw: 1'b1, default: 1'b0};
      OP_LOAD:                      return '{rw: 1'b1, mr: 1'b1, default: 1'b0};
      OP_STORE:                     return '{mw: 1'b1, default: 1'b0};
      OP_BRANCH:                    return '{br: 1'b1, default: 1'b0};
      OP_JAL, OP_JALR:              return '{rw: 1'b1, jp: 1'b1, default: 1'b0};
      default:                      return '0;
    endcase
  endfunction

  // Expected outputs for one cycle of an instruction, given which phase it is in.
  function automatic out_t model(input phase_e ph, input logic [6:0] op, input logic [4:0] rd,
                                 input logic ready, input logic taken);
    dec_t d;
    out_t o;
    d = decode(op);
    o = '0;
    o.retire_count = model_cnt;
    case (ph)
      PH_F: begin o.mem_req = 1'b1; o.ir_load = ready; o.state_dbg = 3'd0; end
      PH_D: o.state_dbg = 3'd1;
      PH_E: begin
        o.state_dbg = 3'd2;
        o.alu_a_sel = (op == OP_AUIPC);
        if (d.br) begin o.pc_write = 1'b1; o.pc_sel = taken ? 2'b01 : 2'b00; o.retire = 1'b1; end
      end
      PH_M: begin
        o.state_dbg = 3'd3; o.mem_req = 1'b1; o.mem_addr_sel = 1'b1; o.mem_we = d.mw;
        if (ready && d.mw) begin o.pc_write = 1'b1; o.retire = 1'b1; end
      end
      PH_W: begin
        o.state_dbg = 3'd4;
        o.rf_we     = d.rw && (rd != 5'd0);
        o.wb_sel    = d.mr ? 2'b01 : d.jp ? 2'b10 : (op == OP_LUI) ? 2'b11 : 2'b00;
        o.alu_a_sel = (op == OP_AUIPC);
        o.pc_write  = 1'b1;
        o.pc_sel    = (op == OP_JAL) ? 2'b01 : (op == OP_JALR) ? 2'b10 : 2'b00;
        o.retire    = 1'b1;
      end
      default: ;
    endcase
    return o;
  endfunction

  function automatic out_t trap_out(input logic [1:0] cause);
    out_t o;
    o = '0;
    o.trap = 1'b1; o.trap_cause = cause; o.state_dbg = 3'd5; o.retire_count = model_cnt;
    return o;
  endfunction

  task automatic drive_dec(input logic [6:0] op, input logic [4:0] rd);
    dec_t d;
    d = decode(op);
    dec_opcode = op; dec_rd = rd;
    dec_reg_write = d.rw; dec_mem_read = d.mr; dec_mem_write = d.mw;
    dec_branch = d.br; dec_jump = d.jp;
  endtask

  // Runs one instruction from FETCH to retire; called and returns at posedge+1.
  task automatic run_instr(input logic [6:0] op, input logic [4:0] rd, input int fw, input int mw,
                           input logic taken, output int cyc, output logic rf_any,
                           output logic [1:0] wb_r, output logic [1:0] pc_r);
    dec_t   d;
    phase_e ph[$];
    logic   rdy[$];
    out_t   act;
    d = decode(op);
    drive_dec(op, rd);
    for (int i = 0; i <= fw; i++) begin ph.push_back(PH_F); rdy.push_back(i == fw); end
    ph.push_back(PH_D); rdy.push_back(1'($urandom));
    ph.push_back(PH_E); rdy.push_back(1'($urandom));
    if (d.mr || d.mw) begin
      for (int j = 0; j <= mw; j++) begin ph.push_back(PH_M); rdy.push_back(j == mw); end
    end
    if (!d.br && !d.mw) begin ph.push_back(PH_W); rdy.push_back(1'($urandom)); end
    cyc = 0; rf_any = 1'b0; wb_r = 2'b00; pc_r = 2'b00;
    for (int k = 0; k < ph.size(); k++) begin
      mem_ready    = rdy[k];
      branch_taken = taken;
      @(negedge clk);
      act = sample();
      check($sformatf("cycle op=%b k=%0d", op, k), 64'(act), 64'(model(ph[k], op, rd, rdy[k], taken)));
      if (act.rf_we) rf_any = 1'b1;
      if (act.retire && cyc == 0) begin cyc = k + 1; wb_r = act.wb_sel; pc_r = act.pc_sel; end
      @(posedge clk); #1;
    end
    model_cnt = model_cnt + 1'b1;
    mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("outputs during reset", 64'(sample()), 64'(0));
    @(posedge clk); #1;
    check("outputs held in reset", 64'(sample()), 64'(0));
    rst = 1'b0;
    model_cnt = '0;
  endtask

  vec_t       vt[11];
  logic [6:0] legal_ops[9];

  initial begin
    int         cyc;
    logic       rf_any;
    logic [1:0] wb_r, pc_r;

    vt[0]  = '{OP_I,      5'd5, 0, 0, 1'b0, 4, 1'b1, 2'b00, 2'b00};
    vt[1]  = '{OP_LOAD,   5'd7, 0, 3, 1'b0, 8, 1'b1, 2'b01, 2'b00};
    vt[2]  = '{OP_STORE,  5'd0, 0, 0, 1'b0, 4, 1'b0, 2'b00, 2'b00};
    vt[3]  = '{OP_I,      5'd0, 0, 0, 1'b0, 4, 1'b0, 2'b00, 2'b00};
    vt[4]  = '{OP_BRANCH, 5'd0, 0, 0, 1'b1, 3, 1'b0, 2'b00, 2'b01};
    vt[5]  = '{OP_BRANCH, 5'd0, 0, 0, 1'b0, 3, 1'b0, 2'b00, 2'b00};
    vt[6]  = '{OP_JAL,    5'd1, 0, 0, 1'b0, 4, 1'b1, 2'b10, 2'b01};
    vt[7]  = '{OP_JALR,   5'd1, 0, 0, 1'b0, 4, 1'b1, 2'b10, 2'b10};
    vt[8]  = '{OP_LUI,    5'd3, 0, 0, 1'b0, 4, 1'b1, 2'b11, 2'b00};
    vt[9]  = '{OP_AUIPC,  5'd4, 0, 0, 1'b0, 4, 1'b1, 2'b00, 2'b00};
    vt[10] = '{OP_R,      5'd9, 2, 0, 1'b0, 6, 1'b1, 2'b00, 2'b00};
    legal_ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

    rst = 1'b1; mem_ready = 1'b0; branch_taken = 1'b0;
    drive_dec(OP_I, 5'd0);
    model_cnt = '0;
    @(posedge clk); #1;
    do_reset();

    foreach (vt[i]) begin
      run_instr(vt[i].op, vt[i].rd, vt[i].fw, vt[i].mw, vt[i].taken, cyc, rf_any, wb_r, pc_r);
      check($sformatf("vec%0d cycles", i), 64'(cyc), 64'(vt[i].cyc));
      check($sformatf("vec%0d rf_we", i), 64'(rf_any), 64'(vt[i].rf));
      check($sformatf("vec%0d wb_sel", i), 64'(wb_r), 64'(vt[i].wb));
      check($sformatf("vec%0d pc_sel", i), 64'(pc_r), 64'(vt[i].pc));
    end

    // Random stream long enough to wrap the narrow retire counter.
    for (int n = 0; n < 40; n++) begin
      run_instr(legal_ops[$urandom_range(0, 8)], 5'($urandom), $urandom_range(0, 3),
                $urandom_range(0, 3), 1'($urandom), cyc, rf_any, wb_r, pc_r);
    end
    @(negedge clk);
    check("retire_count after stream", 64'(retire_count), 64'(model_cnt));
    @(posedge clk); #1;

    // Illegal opcode: trap the cycle after DECODE, sticky thereafter.
    drive_dec(OP_SYSTEM, 5'd2);
    mem_ready = 1'b1;
    @(negedge clk);
    check("illegal fetch", 64'(sample()), 64'(model(PH_F, OP_SYSTEM, 5'd2, 1'b1, 1'b0)));
    @(posedge clk); #1;
    @(negedge clk);
    check("illegal decode", 64'(sample()), 64'(model(PH_D, OP_SYSTEM, 5'd2, 1'b1, 1'b0)));
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      mem_ready = 1'($urandom);
      @(negedge clk);
      check($sformatf("illegal trap c=%0d", c), 64'(sample()), 64'(trap_out(2'b01)));
    end
    @(posedge clk); #1;
    do_reset();

    // Fetch timeout: 255 waiting cycles, then TRAP with cause 10.
    drive_dec(OP_I, 5'd1);
    mem_ready = 1'b0;
    for (int c = 0; c < TMO; c++) begin
      @(negedge clk);
      check($sformatf("timeout wait c=%0d", c), 64'(sample()), 64'(model(PH_F, OP_I, 5'd1, 1'b0, 1'b0)));
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("timeout trap", 64'(sample()), 64'(trap_out(2'b10)));
    @(posedge clk); #1;
    do_reset();

    // Ready arriving in the final allowed cycle completes the access.
    run_instr(OP_I, 5'd6, TMO - 1, 0, 1'b0, cyc, rf_any, wb_r, pc_r);
    check("late ready cycles", 64'(cyc), 64'(TMO + 3));

    // Reset during the MEM wait of a load.
    run_instr(OP_R, 5'd8, 0, 0, 1'b0, cyc, rf_any, wb_r, pc_r);
    drive_dec(OP_LOAD, 5'd10);
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("load in MEM", 64'(sample()), 64'(model(PH_M, OP_LOAD, 5'd10, 1'b0, 1'b0)));
    #2;
    rst = 1'b1;
    #1;
    check("async reset mid-MEM", 64'(sample()), 64'(0));
    @(posedge clk); #1;
    check("reset held mid-MEM", 64'(sample()), 64'(0));
    rst = 1'b0;
    model_cnt = '0;
    run_instr(OP_I, 5'd5, 0, 0, 1'b0, cyc, rf_any, wb_r, pc_r);
    @(negedge clk);
    check("retire_count after reset", 64'(retire_count), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
